intr_arbiter: RTL and testbench

Shares the tramelblaze_top single INTERRUPT/INTERRUPT_ACK pair between up to 8 peripheral interrupt sources, such as UART TX-done and RX-ready.
- Latches source edges as pending bits.
- Applies a CPU-programmable mask.
- Picks a fixed-priority winner, raises INTERRUPT, and records the winner's ID on INTERRUPT_ACK.
- Holds off further interrupts until firmware writes end-of-interrupt (EOI) through the tramelblaze port bus.
- Sits beside the processor; its read data is muxed into IN_PORT.

---
 rtl/intr_pkg.sv | 15 +
 rtl/intr_if.sv | 26 ++
 rtl/intr_edge_detect.sv | 25 ++
 rtl/intr_arbiter.sv | 133 +++++++++++++
 tb/tb_intr_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt arbiter.
// Register offsets are relative to the block's base port.
package intr_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_e;

  localparam logic [15:0] OFS_PEND   = 16'd0;
  localparam logic [15:0] OFS_MASK   = 16'd1;
  localparam logic [15:0] OFS_ACTIVE = 16'd2;

  localparam int ACT_VLD_BIT = 15;
endpackage

// File: rtl/intr_if.sv
// tramelblaze port bus plus the INTERRUPT/ACK pair.
// master = CPU side, slave = arbiter side.
interface intr_if;
  import intr_pkg::*;

  logic [15:0] PORT_ID;
  logic [15:0] OUT_PORT;
  logic        WRITE_STROBE;
  logic        READ_STROBE;
  logic        INTERRUPT_ACK;
  logic        INTERRUPT;
  logic [15:0] RD_DATA;
  logic        RD_HIT;

  modport master (
    output PORT_ID, OUT_PORT, WRITE_STROBE,
    output READ_STROBE, INTERRUPT_ACK,
    input  INTERRUPT, RD_DATA, RD_HIT
  );

  modport slave (
    input  PORT_ID, OUT_PORT, WRITE_STROBE,
    input  READ_STROBE, INTERRUPT_ACK,
    output INTERRUPT, RD_DATA, RD_HIT
  );
endinterface

// File: rtl/intr_edge_detect.sv
// Rising-edge detector per source; reset preloads both flops
// with the live level so a source held high gives no event.
module intr_edge_detect #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] req_i,
  output logic [W-1:0] evt_o
);
  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= req_i;
      s2_q <= req_i;
    end else begin
      s1_q <= req_i;
      s2_q <= s1_q;
    end
  end

  assign evt_o = s1_q & ~s2_q;
endmodule

// File: rtl/intr_arbiter.sv
// Fixed-priority interrupt arbiter sharing one INTERRUPT/ACK
// pair between NUM_SRC edge-triggered sources.
module intr_arbiter
  import intr_pkg::*;
#(
  parameter int          NUM_SRC   = 4,
  parameter logic [15:0] BASE_PORT = 16'h00F0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] SRC_REQ,
  intr_if.slave              bus
);
  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [2:0]         act_id_q, act_id_d;
  logic               act_vld_q, act_vld_d;
  logic               irq_q;

  logic [NUM_SRC-1:0] evt;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] win_oh;
  logic [NUM_SRC-1:0] w1c;
  logic [2:0]         win;
  logic               take;
  logic [15:0]        ofs;
  logic               hit;
  logic               wr_pend, wr_mask, wr_act;
  logic [15:0]        rd;
  logic               unused_bits;

  intr_edge_detect #(.W(NUM_SRC)) u_edge (
    .clk_i (CLK),
    .rst_i (RESET),
    .req_i (SRC_REQ),
    .evt_o (evt)
  );

  // Offset arithmetic wraps, so one compare covers the window.
  assign ofs     = bus.PORT_ID - BASE_PORT;
  assign hit     = ofs <= OFS_ACTIVE;
  assign wr_pend = bus.WRITE_STROBE && ofs == OFS_PEND;
  assign wr_mask = bus.WRITE_STROBE && ofs == OFS_MASK;
  assign wr_act  = bus.WRITE_STROBE && ofs == OFS_ACTIVE;
  assign w1c     = wr_pend ? bus.OUT_PORT[NUM_SRC-1:0] : '0;
  assign cand    = pend_q & mask_q;

  assign unused_bits = ^{bus.READ_STROBE, bus.OUT_PORT};

  always_comb begin
    win    = 3'd0;
    win_oh = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win       = 3'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    act_id_d  = act_id_q;
    act_vld_d = act_vld_q;
    take      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|cand) state_d = ASSERT;
      end
      ASSERT: begin
        if (bus.INTERRUPT_ACK && |cand) begin
          take      = 1'b1;
          act_id_d  = win;
          act_vld_d = 1'b1;
          state_d   = SERVICE;
        end else if (!(|cand)) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (wr_act) begin
          act_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // New events are ORed in last so they beat any clear.
    pend_d = pend_q & ~w1c;
    if (take) pend_d = pend_d & ~win_oh;
    pend_d = pend_d | evt;
    mask_d = wr_mask ? bus.OUT_PORT[NUM_SRC-1:0] : mask_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      mask_q    <= '0;
      act_id_q  <= 3'd0;
      act_vld_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      act_id_q  <= act_id_d;
      act_vld_q <= act_vld_d;
      irq_q     <= state_d == ASSERT;
    end
  end

  always_comb begin
    rd = '0;
    if (hit) begin
      unique case (1'b1)
        ofs == OFS_PEND: rd = 16'(pend_q);
        ofs == OFS_MASK: rd = 16'(mask_q);
        ofs == OFS_ACTIVE: begin
          rd[ACT_VLD_BIT] = act_vld_q;
          rd[2:0]         = act_id_q;
        end
        default: rd = '0;
      endcase
    end
  end

  assign bus.INTERRUPT = irq_q;
  assign bus.RD_DATA   = rd;
  assign bus.RD_HIT    = hit;
endmodule

// File: tb/tb_intr_arbiter.sv
// Bench for intr_arbiter: directed vector table, hand sequences
// for reset corner cases, then random traffic vs a reference model.
module tb_intr_arbiter;
  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  SRC_REQ;

  logic        d_rst;
  logic [3:0]  d_src;
  logic [15:0] d_pid, d_out;
  logic        d_ws, d_ack;

  int n_chk = 0;
  int n_err = 0;

  intr_if bus();

  assign RESET             = d_rst;
  assign SRC_REQ           = d_src;
  assign bus.PORT_ID       = d_pid;
  assign bus.OUT_PORT      = d_out;
  assign bus.WRITE_STROBE  = d_ws;
  assign bus.READ_STROBE   = !d_ws;
  assign bus.INTERRUPT_ACK = d_ack;

  intr_arbiter #(
    .NUM_SRC   (4),
    .BASE_PORT (16'h00F0)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .SRC_REQ (SRC_REQ),
    .bus     (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Reference model: phase 0=idle, 1=requesting, 2=in service.
  bit [3:0] m_s1, m_s2;
  int m_pend, m_mask, m_phase, m_id;
  bit m_vld, m_irq;

  function automatic int m_read(logic [15:0] pid);
    if (pid == 16'h00F0) return m_pend;
    if (pid == 16'h00F1) return m_mask;
    if (pid == 16'h00F2) return (m_vld ? 32'h8000 : 0) | m_id;
    return 0;
  endfunction

  function automatic void model_update();
    int cand, evt, clr, nph, w;
    if (d_rst) begin
      m_pend = 0; m_mask = 0; m_phase = 0;
      m_id = 0; m_vld = 0; m_irq = 0;
      m_s1 = d_src; m_s2 = d_src;
      return;
    end
    cand = m_pend & m_mask;
    evt  = 32'(m_s1 & ~m_s2);
    clr  = (d_ws && d_pid == 16'h00F0) ? (d_out & 15) : 0;
    nph  = m_phase;
    case (m_phase)
      0: if (cand != 0) nph = 1;
      1: begin
        if (cand == 0) nph = 0;
        else if (d_ack) begin
          w = 0;
          while (!cand[w]) w++;
          m_id = w; m_vld = 1; clr |= (1 << w); nph = 2;
        end
      end
      default: if (d_ws && d_pid == 16'h00F2) begin
        m_vld = 0; nph = 0;
      end
    endcase
    m_pend = (m_pend & ~clr) | evt;
    if (d_ws && d_pid == 16'h00F1) m_mask = d_out & 15;
    m_phase = nph;
    m_irq = (nph == 1);
    m_s2 = m_s1;
    m_s1 = d_src;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic settle_check();
    #1;
    chk("model irq", 32'(bus.INTERRUPT), 32'(m_irq));
    chk("model rd", 32'(bus.RD_DATA), m_read(d_pid));
    chk("model hit", 32'(bus.RD_HIT),
        32'(d_pid >= 16'h00F0 && d_pid <= 16'h00F2));
  endtask

  task automatic tick();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  typedef struct {
    logic [15:0] pid, out;
    logic        ws, ack;
    logic [3:0]  src;
    logic        e_irq, e_hit;
    logic [15:0] e_rd;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mkv(logic [15:0] pid, logic [15:0] out,
                               logic ws, logic ack, logic [3:0] src,
                               logic irq, logic [15:0] rd);
    vec_t v;
    v.pid = pid; v.out = out; v.ws = ws; v.ack = ack; v.src = src;
    v.e_irq = irq; v.e_rd = rd;
    v.e_hit = (pid >= 16'h00F0 && pid <= 16'h00F2);
    return v;
  endfunction

  initial begin
    // pid, out, ws, ack, src, exp irq, exp rd (before the edge)
    tv.push_back(mkv(16'hF1, 16'h000F, 1, 0, 4'h0, 0, 16'h0000));
    tv.push_back(mkv(16'hF1, 16'h0000, 0, 0, 4'h4, 0, 16'h000F));
    tv.push_back(mkv(16'hF0, 16'h0000, 0, 0, 4'h0, 0, 16'h0000));
    tv.push_back(mkv(16'hF0, 16'h0000, 0, 0, 4'h0, 0, 16'h0004));
    tv.push_back(mkv(16'hF2, 16'h0000, 0, 1, 4'h0, 1, 16'h0000));
    tv.push_back(mkv(16'hF2, 16'h0000, 0, 0, 4'h0, 0, 16'h8002));
    tv.push_back(mkv(16'hF0, 16'h0000, 0, 0, 4'h0, 0, 16'h0000));
    tv.push_back(mkv(16'hF2, 16'h0000, 1, 0, 4'h0, 0, 16'h8002));
    tv.push_back(mkv(16'hF2, 16'h0000, 0, 0, 4'h0, 0, 16'h0002));
    tv.push_back(mkv(16'hF0, 16'h0000, 0, 0, 4'hA, 0, 16'h0000));
    tv.push_back(mkv(16'hF0, 16'h0000, 0, 0, 4'hA, 0, 16'h0000));
    tv.push_back(mkv(16'hF0, 16'h0000, 0, 0, 4'hA, 0, 16'h000A));
    tv.push_back(mkv(16'hF2, 16'h0000, 0, 1, 4'hA, 1, 16'h0002));
    tv.push_back(mkv(16'hF2, 16'h0000, 0, 0, 4'hA, 0, 16'h8001));
    tv.push_back(mkv(16'hF0, 16'h0000, 0, 0, 4'hA, 0, 16'h0008));
    tv.push_back(mkv(16'hF2, 16'h0000, 1, 0, 4'hA, 0, 16'h8001));
    tv.push_back(mkv(16'hF2, 16'h0000, 0, 0, 4'hA, 0, 16'h0001));
    tv.push_back(mkv(16'hF0, 16'h0000, 0, 0, 4'hA, 1, 16'h0008));
    tv.push_back(mkv(16'hF2, 16'h0000, 0, 1, 4'hA, 1, 16'h0001));
    tv.push_back(mkv(16'hF2, 16'h0000, 0, 0, 4'hA, 0, 16'h8003));
    tv.push_back(mkv(16'hF2, 16'h0000, 1, 0, 4'hA, 0, 16'h8003));
    tv.push_back(mkv(16'hF3, 16'h0000, 0, 0, 4'hA, 0, 16'h0000));
    tv.push_back(mkv(16'hF1, 16'h0000, 1, 0, 4'h0, 0, 16'h000F));
    tv.push_back(mkv(16'hF1, 16'h0000, 0, 0, 4'h1, 0, 16'h0000));
    tv.push_back(mkv(16'hF0, 16'h0000, 0, 0, 4'h0, 0, 16'h0000));
    tv.push_back(mkv(16'hF0, 16'h0000, 0, 0, 4'h0, 0, 16'h0001));
    tv.push_back(mkv(16'hF0, 16'h0000, 0, 0, 4'h0, 0, 16'h0001));
    tv.push_back(mkv(16'hF1, 16'hFFF1, 1, 0, 4'h0, 0, 16'h0000));
    tv.push_back(mkv(16'hF1, 16'h0000, 0, 0, 4'h0, 0, 16'h0001));
    tv.push_back(mkv(16'hF0, 16'h0000, 0, 0, 4'h0, 1, 16'h0001));
    tv.push_back(mkv(16'hF0, 16'h0001, 1, 0, 4'h0, 1, 16'h0001));
    tv.push_back(mkv(16'hF0, 16'h0000, 0, 0, 4'h0, 1, 16'h0000));
    tv.push_back(mkv(16'hF2, 16'h0000, 0, 1, 4'h0, 0, 16'h0003));
    tv.push_back(mkv(16'hF2, 16'h0000, 1, 0, 4'h0, 0, 16'h0003));
    tv.push_back(mkv(16'hF2, 16'h0000, 0, 0, 4'h0, 0, 16'h0003));

    d_rst = 1; d_src = 0; d_pid = 16'hF0; d_out = 0;
    d_ws = 0; d_ack = 0;
    tick(); tick();
    d_rst = 0;

    foreach (tv[i]) begin
      d_pid = tv[i].pid; d_out = tv[i].out; d_ws = tv[i].ws;
      d_ack = tv[i].ack; d_src = tv[i].src;
      settle_check();
      chk($sformatf("tv%0d irq", i), 32'(bus.INTERRUPT), 32'(tv[i].e_irq));
      chk($sformatf("tv%0d rd", i), 32'(bus.RD_DATA), 32'(tv[i].e_rd));
      chk($sformatf("tv%0d hit", i), 32'(bus.RD_HIT), 32'(tv[i].e_hit));
      tick();
    end
    d_ws = 0; d_ack = 0;

    // Source held high through reset release: no event.
    d_rst = 1; d_src = 4'h1; d_pid = 16'hF0;
    tick(); tick();
    d_rst = 0;
    tick(); tick(); tick();
    settle_check();
    chk("hold pend", 32'(bus.RD_DATA), 32'h0);
    d_pid = 16'hF1; d_ws = 1; d_out = 16'h0001;
    settle_check(); tick();
    d_ws = 0; d_pid = 16'hF0;
    tick(); tick();
    settle_check();
    chk("hold pend2", 32'(bus.RD_DATA), 32'h0);
    chk("hold irq", 32'(bus.INTERRUPT), 32'h0);

    d_src = 0; tick();
    d_src = 4'h1; tick(); tick(); tick();
    settle_check();
    chk("svc irq up", 32'(bus.INTERRUPT), 32'h1);
    d_pid = 16'hF2; d_ack = 1;
    settle_check(); tick();
    d_ack = 0;
    settle_check();
    chk("svc act", 32'(bus.RD_DATA), 32'h8000);

    // Event during service stays pending until EOI.
    d_src = 0; tick();
    d_src = 4'h1; tick(); tick(); tick();
    d_pid = 16'hF0;
    settle_check();
    chk("svc pend", 32'(bus.RD_DATA), 32'h1);
    chk("svc irq low", 32'(bus.INTERRUPT), 32'h0);
    d_pid = 16'hF2; d_ws = 1; d_out = 0;
    settle_check(); tick();
    d_ws = 0; tick();
    settle_check();
    chk("eoi irq", 32'(bus.INTERRUPT), 32'h1);

    // Reset while in service, then stray ACK and EOI.
    d_ack = 1; tick();
    d_ack = 0;
    settle_check();
    chk("pre rst act", 32'(bus.RD_DATA), 32'h8000);
    d_rst = 1; tick();
    d_rst = 0;
    settle_check();
    chk("rst act", 32'(bus.RD_DATA), 32'h0);
    chk("rst irq", 32'(bus.INTERRUPT), 32'h0);
    d_pid = 16'hF1;
    settle_check();
    chk("rst mask", 32'(bus.RD_DATA), 32'h0);
    d_ack = 1; tick();
    d_ack = 0; d_pid = 16'hF2; d_ws = 1; tick();
    d_ws = 0;
    settle_check();
    chk("stray act", 32'(bus.RD_DATA), 32'h0);
    chk("stray irq", 32'(bus.INTERRUPT), 32'h0);

    for (int c = 0; c < 4000; c++) begin
      d_rst = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) d_src[b] = ~d_src[b];
      case ($urandom_range(0, 4))
        0: d_pid = 16'h00F0;
        1: d_pid = 16'h00F1;
        2: d_pid = 16'h00F2;
        3: d_pid = 16'h00F3;
        default: d_pid = 16'($urandom);
      endcase
      d_ws  = ($urandom_range(0, 3) == 0);
      d_out = 16'($urandom);
      d_ack = ($urandom_range(0, 2) == 0);
      settle_check();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
